// File: rtl/card_pkg.sv
// Shared definitions for the card-matching controller: entry field layout,
// FSM state encoding, pair colours and the fixed card layouts.
package card_pkg;

    localparam int unsigned ACTIVE_BIT = 0;
    localparam int unsigned DISC_BIT   = 1;
    localparam int unsigned COLOR_MSB  = 13;
    localparam int unsigned COLOR_LSB  = 2;

    localparam int unsigned NUM_CARDS  = 12;
    localparam int unsigned NUM_PAIRS  = 6;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        WAIT_FIRST,
        REVEAL_FIRST,
        WAIT_SECOND,
        REVEAL_SECOND,
        SHOW,
        RESOLVE_A,
        RESOLVE_B,
        DONE
    } state_t;

    localparam logic [11:0] PAIR_COLOR [0:5] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F
    };

    localparam logic [2:0] CARD_LAYOUT [0:3][1:12] = '{
        '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5},
        '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5},
        '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5},
        '{3'd0, 3'd1, 3'd0, 3'd2, 3'd1, 3'd3, 3'd2, 3'd4, 3'd3, 3'd5, 3'd4, 3'd5}
    };

    // Covered, undiscovered card for the valid range; blank entry elsewhere.
    function automatic logic [13:0] init_entry(input logic [1:0] layout,
                                               input logic [3:0] addr);
        if (addr >= 4'd1 && addr <= 4'(NUM_CARDS))
            return {PAIR_COLOR[CARD_LAYOUT[layout][addr]], 1'b0, 1'b1};
        return '0;
    endfunction

endpackage

// File: rtl/show_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module show_timer #(
    parameter int unsigned WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign done = (count == '0);

endmodule

// File: rtl/card_match_ctl.sv
// Memory-game controller: initialises the card register file, accepts pair
// selections, shows each pair for SHOW_CYCLES, then retires or covers it.
module card_match_ctl
    import card_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES = 65_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  layout,
    input  logic        sel_valid,
    input  logic [3:0]  sel_addr,
    output logic [3:0]  rf_r_address,
    input  logic [13:0] rf_r_data,
    output logic        rf_w_enable,
    output logic [3:0]  rf_w_address,
    output logic [13:0] rf_w_data,
    output logic        busy,
    output logic [2:0]  pairs_found,
    output logic [7:0]  moves,
    output logic        game_over
);

    localparam int unsigned TW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES - 1);

    state_t      state;
    logic [1:0]  layout_q;
    logic [3:0]  first_addr, second_addr;
    logic [11:0] first_color, second_color;
    logic        in_wait, sel_ok, match, show_done;

    assign in_wait = (state == WAIT_FIRST) || (state == WAIT_SECOND);
    assign match   = (first_color == second_color);

    always_comb begin
        rf_r_address = in_wait ? sel_addr : '0;
        sel_ok = in_wait && sel_valid
              && sel_addr >= 4'd1 && sel_addr <= 4'(NUM_CARDS)
              && rf_r_data[ACTIVE_BIT] && !rf_r_data[DISC_BIT]
              && !(state == WAIT_SECOND && sel_addr == first_addr);
    end

    // Loaded during the reveal write so SHOW lasts exactly SHOW_CYCLES cycles.
    show_timer #(.WIDTH(TW)) u_show_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (state == REVEAL_SECOND),
        .load_value (SHOW_LOAD),
        .done       (show_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            layout_q     <= '0;
            first_addr   <= '0;
            second_addr  <= '0;
            first_color  <= '0;
            second_color <= '0;
            rf_w_enable  <= 1'b0;
            rf_w_address <= '0;
            rf_w_data    <= '0;
            busy         <= 1'b1;
            pairs_found  <= '0;
            moves        <= '0;
            game_over    <= 1'b0;
        end else begin
            rf_w_enable <= 1'b0;
            if (start) begin
                state        <= INIT;
                layout_q     <= layout;
                first_addr   <= '0;
                second_addr  <= '0;
                first_color  <= '0;
                second_color <= '0;
                rf_w_enable  <= 1'b1;
                rf_w_address <= '0;
                rf_w_data    <= '0;
                busy         <= 1'b1;
                pairs_found  <= '0;
                moves        <= '0;
                game_over    <= 1'b0;
            end else begin
                case (state)
                    INIT: begin
                        // The write address doubles as the sweep counter.
                        if (rf_w_address == 4'd15) begin
                            state <= WAIT_FIRST;
                            busy  <= 1'b0;
                        end else begin
                            rf_w_enable  <= 1'b1;
                            rf_w_address <= rf_w_address + 4'd1;
                            rf_w_data    <= init_entry(layout_q, rf_w_address + 4'd1);
                        end
                    end
                    WAIT_FIRST: if (sel_ok) begin
                        first_addr   <= sel_addr;
                        first_color  <= rf_r_data[COLOR_MSB:COLOR_LSB];
                        state        <= REVEAL_FIRST;
                        busy         <= 1'b1;
                        rf_w_enable  <= 1'b1;
                        rf_w_address <= sel_addr;
                        rf_w_data    <= {rf_r_data[COLOR_MSB:COLOR_LSB], 2'b11};
                    end
                    REVEAL_FIRST: begin
                        state <= WAIT_SECOND;
                        busy  <= 1'b0;
                    end
                    WAIT_SECOND: if (sel_ok) begin
                        second_addr  <= sel_addr;
                        second_color <= rf_r_data[COLOR_MSB:COLOR_LSB];
                        state        <= REVEAL_SECOND;
                        busy         <= 1'b1;
                        rf_w_enable  <= 1'b1;
                        rf_w_address <= sel_addr;
                        rf_w_data    <= {rf_r_data[COLOR_MSB:COLOR_LSB], 2'b11};
                    end
                    REVEAL_SECOND: state <= SHOW;
                    SHOW: if (show_done) begin
                        state        <= RESOLVE_A;
                        rf_w_enable  <= 1'b1;
                        rf_w_address <= first_addr;
                        rf_w_data    <= {first_color, match, !match};
                    end
                    RESOLVE_A: begin
                        state        <= RESOLVE_B;
                        rf_w_enable  <= 1'b1;
                        rf_w_address <= second_addr;
                        rf_w_data    <= {second_color, match, !match};
                    end
                    RESOLVE_B: begin
                        if (moves != 8'hFF)
                            moves <= moves + 8'd1;
                        if (match)
                            pairs_found <= pairs_found + 3'd1;
                        if (match && pairs_found == 3'(NUM_PAIRS - 1)) begin
                            state     <= DONE;
                            game_over <= 1'b1;
                        end else begin
                            state <= WAIT_FIRST;
                            busy  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_card_match_ctl.sv
// Self-checking bench for card_match_ctl with a behavioural register file and
// a write scoreboard fed by the stimulus tasks.
module tb_card_match_ctl;

    localparam int unsigned S = 4;

    logic        clk = 1'b0;
    logic        rst_n, start, sel_valid;
    logic [1:0]  layout;
    logic [3:0]  sel_addr, rf_r_address, rf_w_address;
    logic [13:0] rf_r_data, rf_w_data;
    logic        rf_w_enable, busy, game_over;
    logic [2:0]  pairs_found;
    logic [7:0]  moves;

    always #5 clk = ~clk;

    card_match_ctl #(.SHOW_CYCLES(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .layout       (layout),
        .sel_valid    (sel_valid),
        .sel_addr     (sel_addr),
        .rf_r_address (rf_r_address),
        .rf_r_data    (rf_r_data),
        .rf_w_enable  (rf_w_enable),
        .rf_w_address (rf_w_address),
        .rf_w_data    (rf_w_data),
        .busy         (busy),
        .pairs_found  (pairs_found),
        .moves        (moves),
        .game_over    (game_over)
    );

    logic [13:0] rf [16];
    always @(posedge clk) if (rf_w_enable === 1'b1) rf[rf_w_address] <= rf_w_data;
    assign rf_r_data = rf[rf_r_address];

    typedef struct { logic [3:0] addr; logic [13:0] data; } wr_t;
    wr_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int exp_pairs = 0;
    int exp_moves = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (rst_n === 1'b1 && rf_w_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h:%0h required=none at %0t",
                         rf_w_address, rf_w_data, $time);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 32'(rf_w_address), 32'(e.addr));
                chk("write_data", 32'(rf_w_data), 32'(e.data));
            end
        end
    end

    // Layout 0 colour of card a (pairs 0..5 repeat across 1..12).
    function automatic logic [11:0] col(input int a);
        case ((a - 1) % 6)
            0: return 12'hF00;
            1: return 12'h0F0;
            2: return 12'h00F;
            3: return 12'hFF0;
            4: return 12'h0FF;
            default: return 12'hF0F;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sel(input int a);
        sel_valid = 1'b1;
        sel_addr  = 4'(a);
        tick();
        sel_valid = 1'b0;
        sel_addr  = '0;
    endtask

    task automatic do_start();
        start  = 1'b1;
        layout = 2'd0;
        for (int a = 0; a < 16; a++)
            exp_q.push_back('{4'(a), (a >= 1 && a <= 12) ? {col(a), 2'b01} : 14'h0});
        tick();
        start = 1'b0;
        exp_pairs = 0;
        exp_moves = 0;
        chk("init_busy_first", 32'(busy), 1);
        chk("init_pairs_clear", 32'(pairs_found), 0);
        chk("init_moves_clear", 32'(moves), 0);
        chk("init_game_over_clear", 32'(game_over), 0);
        repeat (15) tick();
        chk("init_busy_last", 32'(busy), 1);
        tick();
        chk("busy_drop_e17", 32'(busy), 0);
        chk("init_writes_drained", 32'(exp_q.size()), 0);
    endtask

    task automatic first_sel(input int a);
        exp_q.push_back('{4'(a), {col(a), 2'b11}});
        sel(a);
        chk("reveal1_wen", 32'(rf_w_enable), 1);
        tick();
        chk("wait_second_busy", 32'(busy), 0);
    endtask

    task automatic second_sel(input int a, input int b, input int poke);
        logic m;
        m = (col(a) == col(b));
        exp_q.push_back('{4'(b), {col(b), 2'b11}});
        exp_q.push_back('{4'(a), {col(a), m, !m}});
        exp_q.push_back('{4'(b), {col(b), m, !m}});
        sel(b);
        chk("reveal2_wen", 32'(rf_w_enable), 1);
        tick();
        for (int i = 1; i <= int'(S); i++) begin
            chk("show_no_write", 32'(rf_w_enable), 0);
            chk("show_busy", 32'(busy), 1);
            if (poke != 0 && i == 2) begin
                sel_valid = 1'b1;
                sel_addr  = 4'(poke);
            end
            tick();
            sel_valid = 1'b0;
            sel_addr  = '0;
        end
        chk("resolve_a_wen", 32'(rf_w_enable), 1);
        chk("resolve_a_addr", 32'(rf_w_address), 32'(a));
        tick();
        chk("resolve_b_addr", 32'(rf_w_address), 32'(b));
        tick();
        if (exp_moves < 255) exp_moves++;
        if (m) exp_pairs++;
        chk("pairs_found", 32'(pairs_found), 32'(exp_pairs));
        chk("moves", 32'(moves), 32'(exp_moves));
        chk("after_busy", 32'(busy), (exp_pairs == 6) ? 1 : 0);
        chk("after_game_over", 32'(game_over), (exp_pairs == 6) ? 1 : 0);
    endtask

    typedef struct { int addr; logic exp_busy; logic exp_wen; logic accept; } vec_t;
    vec_t vecs[6];

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{0,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{13, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1,  1'b0, 1'b0, 1'b0};
        vecs[3] = '{7,  1'b0, 1'b0, 1'b0};
        vecs[4] = '{15, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{2,  1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 16; i++) rf[i] = '0;

        rst_n = 1'b0; start = 1'b0; layout = '0; sel_valid = 1'b0; sel_addr = '0;
        #12;
        chk("reset_busy", 32'(busy), 1);
        chk("reset_wen", 32'(rf_w_enable), 0);
        chk("reset_waddr", 32'(rf_w_address), 0);
        chk("reset_wdata", 32'(rf_w_data), 0);
        chk("reset_raddr", 32'(rf_r_address), 0);
        chk("reset_pairs", 32'(pairs_found), 0);
        chk("reset_moves", 32'(moves), 0);
        chk("reset_game_over", 32'(game_over), 0);
        tick();
        rst_n = 1'b1;
        tick();

        do_start();
        chk("rf1_init", 32'(rf[1]), 32'h3C01);
        chk("rf7_init", 32'(rf[7]), 32'h3C01);
        chk("rf0_init", 32'(rf[0]), 0);
        chk("rf15_init", 32'(rf[15]), 0);

        first_sel(1);
        second_sel(1, 2, 0);
        chk("rf1_covered", 32'(rf[1]), 32'h3C01);
        chk("rf2_covered", 32'(rf[2]), 32'h03C1);

        first_sel(1);
        second_sel(1, 7, 3);
        chk("rf1_retired", 32'(rf[1]), 32'h3C02);
        chk("rf7_retired", 32'(rf[7]), 32'h3C02);

        foreach (vecs[i]) begin
            if (vecs[i].accept)
                exp_q.push_back('{4'(vecs[i].addr), {col(vecs[i].addr), 2'b11}});
            sel(vecs[i].addr);
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_wen", i), 32'(rf_w_enable), 32'(vecs[i].exp_wen));
        end
        tick();
        sel(2);
        chk("same_card_busy", 32'(busy), 0);
        chk("same_card_wen", 32'(rf_w_enable), 0);
        sel(1);
        chk("retired_second_busy", 32'(busy), 0);
        second_sel(2, 8, 0);

        for (int k = 3; k <= 6; k++) begin
            first_sel(k);
            second_sel(k, k + 6, 0);
        end
        chk("done_moves", 32'(moves), 7);
        sel(4);
        chk("done_ignores_sel_busy", 32'(busy), 1);
        chk("done_ignores_sel_wen", 32'(rf_w_enable), 0);
        chk("done_game_over_held", 32'(game_over), 1);

        do_start();
        first_sel(1);
        second_sel(1, 7, 0);
        first_sel(2);
        exp_q.push_back('{4'd8, {col(8), 2'b11}});
        sel(8);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midreset_busy", 32'(busy), 1);
        chk("midreset_wen", 32'(rf_w_enable), 0);
        chk("midreset_waddr", 32'(rf_w_address), 0);
        chk("midreset_wdata", 32'(rf_w_data), 0);
        chk("midreset_pairs", 32'(pairs_found), 0);
        chk("midreset_moves", 32'(moves), 0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        chk("rf1_reinit", 32'(rf[1]), 32'h3C01);
        chk("rf8_reinit", 32'(rf[8]), 32'h03C1);
        first_sel(1);
        second_sel(1, 7, 0);
        chk("final_queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/card_match_ctl.md
# card_match_ctl

Game controller that owns the card register file's write and read ports. It initializes the 16-entry card store from a fixed layout and accepts player card selections. It reveals selected cards, compares each revealed pair after a visible delay, and then retires matched pairs or covers mismatched ones. It sits between the mouse/selection decoder and the card register file. Its status outputs feed the score/overlay logic.

## Interface
- `SHOW_CYCLES`, default 65_000_000: cycles a revealed pair stays visible before resolution (1 s at 65 MHz); must be ≥1.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a new game.
- `layout` in 2: layout select, sampled on `start`.
- `sel_valid` in 1: one-cycle pulse; the player clicked a card.
- `sel_addr` in 4: address of the clicked card.
- `rf_r_address` out 4: register file read address.
- `rf_r_data` in 14: register file read data, combinational from `rf_r_address`.
- `rf_w_enable` out 1, `rf_w_address` out 4, `rf_w_data` out 14: register file write port.
- `busy` out 1: controller is not accepting selections.
- `pairs_found` out 3: matched pairs, 0..6.
- `moves` out 8: resolved pair attempts, saturating at 255.
- `game_over` out 1: all 6 pairs found.

## Operation
- Entry format: bit0 is active; bit1 is discovered; bits 13:2 are the RGB color, R in the MSBs. Valid cards are at addresses 1..12.
- States: IDLE, INIT, WAIT_FIRST, REVEAL_FIRST, WAIT_SECOND, REVEAL_SECOND, SHOW, RESOLVE_A, RESOLVE_B, DONE.
- IDLE / DONE: `start` → INIT.
  - `start` in any other state also aborts the current game to INIT.
  - INIT clears the pair state, `pairs_found`, `moves` and `game_over`.
- INIT: sweeps addresses 0..15, one write per cycle.
  - Addresses 1..12 get `{PAIR_COLOR[CARD_LAYOUT[layout][a]], 1'b0, 1'b1}`.
  - Addresses 0 and 13..15 get 14'h0.
  - After address 15 the state goes to WAIT_FIRST.
- In WAIT_x, `rf_r_address` = `sel_addr`.
- A selection is accepted only when all of these hold:
  - `sel_valid` is high;
  - `sel_addr` is in 1..12;
  - `rf_r_data[0]` = 1 and `rf_r_data[1]` = 0;
  - in WAIT_SECOND only, `sel_addr` differs from the latched first address.
- Rejected selections are dropped silently.
- Acceptance latches the address and the color, then moves to REVEAL_x.
  - REVEAL_x writes `{color, 1'b1, 1'b1}` to that address.
  - REVEAL_FIRST → WAIT_SECOND; REVEAL_SECOND → SHOW.
- SHOW: counts `SHOW_CYCLES` cycles, then → RESOLVE_A.
- A match means the two latched 12-bit colors are equal.
- RESOLVE_A writes the first card and RESOLVE_B writes the second:
  - Match: `{color, 1'b1, 1'b0}` (card retired, face shown).
  - Mismatch: `{color, 1'b0, 1'b1}` (card covered).
- At the end of RESOLVE_B:
  - `moves` increments, saturating at 255.
  - On a match, `pairs_found` increments.
  - If `pairs_found` reaches 6, the state goes to DONE and `game_over` = 1; otherwise it goes to WAIT_FIRST.
- `sel_valid` is ignored outside the WAIT states.
- `busy` = 0 only in WAIT_FIRST and WAIT_SECOND.

## Timing
- Reset values:
  - state IDLE;
  - `rf_w_enable` 0, `rf_w_address` 0, `rf_w_data` 0, `rf_r_address` 0;
  - `pairs_found` 0, `moves` 0, `game_over` 0;
  - `busy` 1.
- Write outputs are registered; `rf_w_enable` is high exactly in INIT, REVEAL_x and RESOLVE_x cycles. The store updates at the end of that cycle.
- `start` at edge E → the INIT write to address 0 is in cycle E+1 → WAIT_FIRST at E+17.
- Second acceptance in cycle N:
  - reveal write in N+1;
  - SHOW in N+2..N+1+S;
  - RESOLVE_A at N+2+S, RESOLVE_B at N+3+S;
  - WAIT_FIRST or DONE at N+4+S.
- A reset asserted mid-game returns the controller to IDLE immediately. It does not clear the register file; the next `start` rewrites every entry.

## Structure
- Package `card_pkg` holds:
  - field positions (ACTIVE_BIT=0, DISC_BIT=1, COLOR_MSB=13, COLOR_LSB=2);
  - NUM_CARDS=12 and NUM_PAIRS=6;
  - state encoding;
  - `PAIR_COLOR[6]` = F00, 0F0, 00F, FF0, 0FF, F0F;
  - `CARD_LAYOUT[4][1..12]`, where layout 0 is pairs 0,1,2,3,4,5,0,1,2,3,4,5.
- Sub-module `show_timer` (load, count-down, done), instantiated once for SHOW.

## Test plan
Common setup: SHOW_CYCLES=4, layout 0, behavioral regfile model.
- Reset then `start`: 16 consecutive writes.
  - Entry 1 = {F00,0,1} = 14'h3C01; entry 7 = 14'h3C01; entry 0 = 0; entry 15 = 0.
  - `busy` drops at E+17.
- Select 1 then 7:
  - reveal writes 14'h3C03 to each;
  - 4 SHOW cycles, then writes 14'h3C02 to both;
  - `pairs_found`=1, `moves`=1.
- Select 1 then 2:
  - both are revealed, then written back as 14'h3C01 and {0F0,0,1} = 14'h03C1;
  - `pairs_found`=0, `moves`=1.
- Rejections:
  - selecting 0, 13, a retired card, or the same card twice → no write and state unchanged;
  - `sel_valid` during SHOW → ignored.
- Match all 6 pairs → `game_over`=1 and state DONE; a further `sel_valid` is ignored; `start` re-initializes with counters at 0.
- Assert `rst_n` low during SHOW → outputs reach reset values with no clock; a following `start` runs a clean INIT.
